// File: rtl/countdown_ctrl.sv
// Control stage in front of a loadable down-counter: captures a preset, strobes Load,
// paces Dec pulses from a prescaler and reports completion when the counter reads zero.
module countdown_ctrl #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned WIDTH    = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Preset,
  input  logic             Start,
  input  logic             Pause,
  input  logic             Stop,
  input  logic [WIDTH-1:0] CountIn,
  output logic [WIDTH-1:0] LoadValue,
  output logic             Load,
  output logic             Dec,
  output logic             Busy,
  output logic             Done,
  output logic [2:0]       State
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic [PW-1:0]    r_presc;
  logic             r_start_q;
  logic [WIDTH-1:0] r_load_value;
  logic             r_load;
  logic             r_dec;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_state_nxt;
  logic [PW-1:0]    w_presc_nxt;
  logic [PW-1:0]    w_presc_inc;
  logic [WIDTH-1:0] w_load_value_nxt;
  logic             w_load_nxt;
  logic             w_dec_nxt;
  logic             w_start_edge;
  logic             w_pretick;
  logic             w_count_zero;

  assign w_start_edge = Start & ~r_start_q;
  assign w_count_zero = (CountIn == '0);
  // Dec is registered, so it is scheduled one cycle early: it lands while the prescaler shows TICK_DIV-1
  assign w_pretick    = (r_presc == PW'(TICK_DIV - 2));
  assign w_presc_inc  = (r_presc == PW'(TICK_DIV - 1)) ? '0 : r_presc + PW'(1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_start_q    <= 1'b0;
      r_load_value <= '0;
      r_load       <= 1'b0;
      r_dec        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_presc      <= w_presc_nxt;
      r_start_q    <= Start;
      r_load_value <= w_load_value_nxt;
      r_load       <= w_load_nxt;
      r_dec        <= w_dec_nxt;
      r_busy       <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN) ||
                      (w_state_nxt == S_PAUSE);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  // Event priority: Stop, Start edge, Pause, zero detect, tick
  always_comb begin
    w_state_nxt      = r_state;
    w_presc_nxt      = r_presc;
    w_load_value_nxt = r_load_value;
    w_load_nxt       = 1'b0;
    w_dec_nxt        = 1'b0;
    if (Stop) begin
      w_state_nxt = S_IDLE;
      w_presc_nxt = '0;
    end else if (w_start_edge) begin
      w_state_nxt      = S_LOAD;
      w_presc_nxt      = '0;
      w_load_value_nxt = Preset;
      w_load_nxt       = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_presc_nxt = '0;
        end
        S_LOAD: begin
          w_state_nxt = S_RUN;
          w_presc_nxt = '0;
        end
        S_RUN: begin
          if (Pause) begin
            // A tick due right after the pause is kept, not lost
            w_state_nxt = S_PAUSE;
            if (!w_pretick) w_presc_nxt = w_presc_inc;
          end else if (w_count_zero && !r_dec) begin
            w_state_nxt = S_DONE;
          end else begin
            w_presc_nxt = w_presc_inc;
            w_dec_nxt   = w_pretick && !w_count_zero;
          end
        end
        S_PAUSE: begin
          if (!Pause) w_state_nxt = S_RUN;
        end
        S_DONE: begin
          w_presc_nxt = r_presc;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_presc_nxt = '0;
        end
      endcase
    end
  end

  assign LoadValue = r_load_value;
  assign Load      = r_load;
  assign Dec       = r_dec;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign State     = r_state;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Randomized and directed bench for countdown_ctrl against a counted-cycle reference model,
// with a behavioural down-counter closing the CountIn loop.
module tb_countdown_ctrl;

  localparam int TD = 4;
  localparam int W  = 4;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_DONE  = 4;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic [W-1:0] Preset = '0;
  logic         Start = 1'b0;
  logic         Pause = 1'b0;
  logic         Stop = 1'b0;
  logic [W-1:0] CountIn;
  logic [W-1:0] LoadValue;
  logic         Load;
  logic         Dec;
  logic         Busy;
  logic         Done;
  logic [2:0]   State;

  countdown_ctrl #(.TICK_DIV(TD), .WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Preset(Preset), .Start(Start), .Pause(Pause),
    .Stop(Stop), .CountIn(CountIn), .LoadValue(LoadValue), .Load(Load), .Dec(Dec),
    .Busy(Busy), .Done(Done), .State(State)
  );

  always #5 Clk = ~Clk;

  // Downstream counter: loads, decrements, never wraps below zero, ignores reset
  logic [W-1:0] cnt = '0;
  assign CountIn = cnt;
  always @(posedge Clk) begin
    if (Load) cnt <= LoadValue;
    else if (Dec && cnt != '0) cnt <= cnt - W'(1);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;
  int n_dec   = 0;
  int n_load  = 0;
  int last_dec_cyc = 0;

  int           m_state;
  logic [W-1:0] m_lv;
  bit           m_load, m_dec, m_busy, m_done, m_sq;
  int           m_idx;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc_no, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_lv = '0; m_load = 0; m_dec = 0;
    m_busy = 0; m_done = 0; m_sq = 0; m_idx = 0;
  endtask

  // One clock edge of the reference: m_idx is the 1-based number of the counted RUN cycle
  task automatic model_step();
    int  ns;
    bit  nl, nd;
    bit  edge_s;
    ns = m_state; nl = 0; nd = 0;
    edge_s = Start && !m_sq;
    if (Stop) ns = M_IDLE;
    else if (edge_s) begin
      ns = M_LOAD; nl = 1; m_lv = Preset;
    end else begin
      case (m_state)
        M_LOAD: begin ns = M_RUN; m_idx = 1; end
        M_RUN: begin
          if (Pause) begin
            ns = M_PAUSE;
            if (((m_idx + 1) % TD) != 0) m_idx++;
          end else if (CountIn == '0 && !m_dec) ns = M_DONE;
          else begin
            m_idx++;
            nd = ((m_idx % TD) == 0) && (CountIn != '0);
          end
        end
        M_PAUSE: if (!Pause) ns = M_RUN;
        default: ;
      endcase
    end
    m_sq = Start;
    m_state = ns; m_load = nl; m_dec = nd;
    m_busy = (ns == M_LOAD) || (ns == M_RUN) || (ns == M_PAUSE);
    m_done = (ns == M_DONE);
  endtask

  task automatic check_all();
    chk("state", int'(State), m_state);
    chk("load_value", int'(LoadValue), int'(m_lv));
    chk("load", int'(Load), int'(m_load));
    chk("dec", int'(Dec), int'(m_dec));
    chk("busy", int'(Busy), int'(m_busy));
    chk("done", int'(Done), int'(m_done));
    chk("dec_at_zero", int'(Dec && (CountIn == '0)), 0);
  endtask

  // Drive one cycle of inputs (at a negedge), advance the model, check at the next negedge
  task automatic cycle(input bit st, input bit pa, input bit sp, input logic [W-1:0] pr);
    Start = st; Pause = pa; Stop = sp; Preset = pr;
    model_step();
    @(negedge Clk);
    cyc_no++;
    check_all();
    if (Dec) begin n_dec++; last_dec_cyc = cyc_no; end
    if (Load) n_load++;
  endtask

  task automatic idle_cycles(input int n, input logic [W-1:0] pr);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, pr);
  endtask

  initial begin
    int d1, d2, d3;
    bit seen;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    check_all();
    Reset_n = 1'b1;

    // Preset=5: five Decs four cycles apart, Done two cycles after the last
    n_dec = 0;
    cycle(1'b1, 1'b0, 1'b0, 4'd5);
    chk("s1_load", int'(Load), 1);
    chk("s1_lv", int'(LoadValue), 5);
    idle_cycles(4, 4'd5);
    chk("s1_first_dec_run4", int'(Dec), 1);
    idle_cycles(25, 4'd5);
    chk("s1_decs", n_dec, 5);
    chk("s1_cnt_zero", int'(cnt), 0);
    chk("s1_done", int'(Done), 1);

    // Preset=0: LOAD, one RUN cycle, DONE, no Dec
    n_dec = 0;
    cycle(1'b1, 1'b0, 1'b0, 4'd0);
    cycle(1'b0, 1'b0, 1'b0, 4'd0);
    chk("s2_run", int'(State), M_RUN);
    cycle(1'b0, 1'b0, 1'b0, 4'd0);
    chk("s2_done", int'(State), M_DONE);
    idle_cycles(4, 4'd0);
    chk("s2_decs", n_dec, 0);

    // Preset=3 with a 7-cycle pause right after the first Dec
    n_dec = 0; seen = 0;
    cycle(1'b1, 1'b0, 1'b0, 4'd3);
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 4'd3);
      seen = Dec;
    end
    chk("s3_first_dec_seen", int'(seen), 1);
    d1 = last_dec_cyc;
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 4'd3);
    chk("s3_paused", int'(State), M_PAUSE);
    d2 = 0; d3 = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 4'd3);
      if (Dec && d2 == 0) d2 = cyc_no;
      else if (Dec && d3 == 0) d3 = cyc_no;
    end
    chk("s3_gap_paused", d2 - d1, TD + 7);
    chk("s3_gap_normal", d3 - d2, TD);
    chk("s3_decs", n_dec, 3);

    // Preset=9: Stop together with a second Start edge during RUN
    cycle(1'b1, 1'b0, 1'b0, 4'd9);
    idle_cycles(6, 4'd9);
    n_load = 0;
    cycle(1'b1, 1'b0, 1'b1, 4'd9);
    chk("s4_idle", int'(State), M_IDLE);
    chk("s4_load", int'(Load), 0);
    chk("s4_dec", int'(Dec), 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 4'd9);
    chk("s4_no_reload", n_load, 0);
    cycle(1'b0, 1'b0, 1'b0, 4'd9);

    // Preset=6, asynchronous reset mid-RUN, then a normal Preset=2 run
    cycle(1'b1, 1'b0, 1'b0, 4'd6);
    idle_cycles(9, 4'd6);
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("s5_rst_state", int'(State), 0);
    #1 Reset_n = 1'b1;
    n_dec = 0;
    cycle(1'b1, 1'b0, 1'b0, 4'd2);
    idle_cycles(14, 4'd2);
    chk("s5_decs", n_dec, 2);
    chk("s5_done", int'(Done), 1);

    // In DONE: Start held 10 cycles gives one LOAD; Preset=15 counts fully down
    n_load = 0; n_dec = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 4'd15);
    chk("s6_one_load", n_load, 1);
    idle_cycles(60, 4'd15);
    chk("s6_decs", n_dec, 15);
    chk("s6_cnt_zero", int'(cnt), 0);
    chk("s6_done", int'(Done), 1);

    // Random phase: sporadic Start toggles, pauses and stops
    for (int i = 0; i < 2000; i++) begin
      bit st, pa, sp;
      st = ($urandom_range(0, 11) == 0) ? !Start : Start;
      pa = ($urandom_range(0, 9) == 0) ? !Pause : Pause;
      sp = ($urandom_range(0, 59) == 0);
      cycle(st, pa, sp, W'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
